// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer.
//   state_t       - FSM state encoding (IDLE/PLAY/PAUSE/DONE)
//   DEF_*         - default widths and timing constants (50 MHz board clock)
//   tempo_period  - step period in clk cycles for a given tempo selection
package melody_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_STEP_W    = 8;
  localparam int DEF_LAST_STEP = 147;
  localparam int DEF_STEP_DIV  = 6_250_000;
  localparam int DEF_GAP_CYC   = 250_000;

  // tempo_sel 0..3 gives 1x, 2x, 4x, 8x speed.
  function automatic int unsigned tempo_period(input int unsigned div, input logic [1:0] sel);
    return div >> sel;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step cycle counter with a tempo-dependent period latch.
//   clk, rst   - clock, synchronous active-high reset
//   run        - advance the counter this cycle
//   clear      - zero the counter and latch a fresh period (wins over run)
//   tempo_sel  - tempo selection, sampled only on clear or at a step boundary
//   step_tick  - counter is on the last cycle of the current step
//   in_gap     - counter is inside the silent tail of the current step
module step_timer
  import melody_pkg::*;
#(
  parameter int  STEP_DIV = DEF_STEP_DIV,
  parameter int  GAP_CYC  = DEF_GAP_CYC,
  localparam int CNT_W    = $clog2(STEP_DIV),
  localparam int PER_W    = CNT_W + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  input  logic [1:0] tempo_sel,
  output logic       step_tick,
  output logic       in_gap
);

  logic [CNT_W-1:0] cnt;
  logic [PER_W-1:0] period;
  logic [PER_W-1:0] period_sel;

  // period can equal STEP_DIV itself, so it carries one bit more than cnt.
  assign period_sel = PER_W'(tempo_period(int'(STEP_DIV), tempo_sel));
  assign step_tick  = ({1'b0, cnt} == (period - PER_W'(1)));
  assign in_gap     = ({1'b0, cnt} >= (period - PER_W'(GAP_CYC)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      period <= PER_W'(STEP_DIV);
    end else if (clear) begin
      cnt    <= '0;
      period <= period_sel;
    end else if (run) begin
      if (step_tick) begin
        // Tempo changes land only here, so a step is never stretched or cut.
        cnt    <= '0;
        period <= period_sel;
      end else begin
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Timing controller for the note-selection mux.
// Walks step through 0..LAST_STEP at a selectable tempo with start/pause/stop
// and optional looping, and gates the note off for the last GAP_CYC cycles of
// every step so repeated notes are heard separately.
//   clk, rst   - clock, synchronous active-high reset
//   start      - pulse: play from step 0 (IDLE/DONE) or resume (PAUSE)
//   pause      - pulse: freeze playback (PLAY only)
//   stop       - pulse: abort to IDLE with step cleared
//   loop_en    - wrap from LAST_STEP back to 0 instead of finishing
//   tempo_sel  - step period = STEP_DIV >> tempo_sel
//   step       - note mux select
//   gate       - 1 while the note should sound
//   playing    - 1 while in PLAY
//   done       - single-cycle pulse on the final step boundary without loop
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int STEP_W    = DEF_STEP_W,
  parameter int LAST_STEP = DEF_LAST_STEP,
  parameter int STEP_DIV  = DEF_STEP_DIV,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [1:0]        tempo_sel,
  output logic [STEP_W-1:0] step,
  output logic              gate,
  output logic              playing,
  output logic              done
);

  state_t            state, state_n;
  logic [STEP_W-1:0] step_n;
  logic              run, clear, step_tick, in_gap, done_c;

  step_timer #(
    .STEP_DIV (STEP_DIV),
    .GAP_CYC  (GAP_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .clear     (clear),
    .tempo_sel (tempo_sel),
    .step_tick (step_tick),
    .in_gap    (in_gap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    run     = 1'b0;
    clear   = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = PLAY;
          step_n  = '0;
          clear   = 1'b1;
        end
      end
      PLAY: begin
        // The cycle on which pause arrives still counts as a played cycle.
        run = 1'b1;
        if (step_tick) begin
          if (step < STEP_W'(LAST_STEP)) begin
            step_n = step + STEP_W'(1);
          end else if (loop_en) begin
            step_n = '0;
          end else begin
            state_n = DONE;
            done_c  = 1'b1;
          end
        end
        // Reaching the end of the melody takes precedence over a pause.
        if (pause && (state_n == PLAY)) begin
          state_n = PAUSE;
        end
      end
      PAUSE: begin
        if (start) begin
          state_n = PLAY;
        end
      end
      default: state_n = IDLE;
    endcase
    if (stop) begin
      state_n = IDLE;
      step_n  = '0;
      run     = 1'b0;
      clear   = 1'b1;
      done_c  = 1'b0;
    end
  end

  assign playing = (state == PLAY);
  assign gate    = (state == PLAY) && !in_gap;
  assign done    = done_c && !rst;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with a short melody and fast tempo.
// The reference model tracks mode, step and cycles remaining in the current
// step, and every cycle compares step/gate/playing/done against it.
module tb_melody_sequencer;

  localparam int LAST = 3;
  localparam int DIV  = 16;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic [7:0] step;
  logic       gate, playing, done;

  int errors = 0;
  int checks = 0;

  // Model: mode 0=idle 1=play 2=paused 3=finished; left = cycles still to play in this step.
  int m_mode = 0, m_step = 0, m_period = DIV, m_left = DIV;

  logic [7:0] obs_step;
  logic       obs_done, obs_playing, obs_gate;

  melody_sequencer #(
    .STEP_W    (8),
    .LAST_STEP (LAST),
    .STEP_DIV  (DIV),
    .GAP_CYC   (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .loop_en   (loop_en),
    .tempo_sel (tempo_sel),
    .step      (step),
    .gate      (gate),
    .playing   (playing),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs at negedge, advance model at posedge.
  task automatic cyc(input logic r, input logic s, input logic p, input logic t,
                     input logic l, input logic [1:0] ts);
    logic exp_done;
    rst = r; start = s; pause = p; stop = t; loop_en = l; tempo_sel = ts;
    @(negedge clk);
    exp_done = (m_mode == 1) && (m_left == 1) && (m_step == LAST) && !l && !t && !r;
    check("step",    32'(step),    32'(m_step));
    check("gate",    32'(gate),    32'((m_mode == 1) && (m_left > GAP)));
    check("playing", 32'(playing), 32'(m_mode == 1));
    check("done",    32'(done),    32'(exp_done));
    obs_step = step; obs_done = done; obs_playing = playing; obs_gate = gate;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_step = 0; m_period = DIV; m_left = DIV;
    end else if (t) begin
      m_mode = 0; m_step = 0;
    end else begin
      case (m_mode)
        0, 3: if (s) begin
          m_mode = 1; m_step = 0; m_period = DIV >> ts; m_left = m_period;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_period = DIV >> ts;
            m_left   = m_period;
            if (m_step < LAST) m_step++;
            else if (l) m_step = 0;
            else m_mode = 3;
          end
          if (p && m_mode == 1) m_mode = 2;
        end
        2: if (s) m_mode = 1;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic idle(input int n, input logic l, input logic [1:0] ts);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, l, ts);
  endtask

  initial begin
    int n, cnt_a, cnt_b, wraps, prev;
    bit found;
    logic rl;
    logic [1:0] rts;

    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    idle(1, 1'b0, 2'd0);
    check("rst_step", 32'(obs_step), 32'd0);
    check("rst_playing", 32'(obs_playing), 32'd0);

    // Full run without loop: done on the 64th cycle after start.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    check("start_playing", 32'(playing), 32'd1);
    check("start_gate", 32'(gate), 32'd1);
    found = 0; n = 0;
    for (int i = 1; i <= 80 && !found; i++) begin
      idle(1, 1'b0, 2'd0);
      if (obs_done) begin found = 1; n = i; end
    end
    check("done_cycle", 32'(n), 32'd64);
    idle(1, 1'b0, 2'd0);
    check("done_hold_step", 32'(obs_step), 32'd3);
    check("done_not_playing", 32'(obs_playing), 32'd0);
    check("done_single", 32'(obs_done), 32'd0);

    // Looping: 200 cycles in PLAY, three wraps, no done.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    cnt_a = 0; cnt_b = 0; wraps = 0; prev = 0;
    for (int i = 0; i < 200; i++) begin
      idle(1, 1'b1, 2'd0);
      if (obs_done) cnt_a++;
      if (!obs_playing) cnt_b++;
      if (prev == 3 && obs_step == 0) wraps++;
      prev = obs_step;
    end
    check("loop_done_count", 32'(cnt_a), 32'd0);
    check("loop_not_playing", 32'(cnt_b), 32'd0);
    check("loop_wraps", 32'(wraps), 32'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);

    // Pause at cnt=5 of step 2, hold 40 cycles, resume: 10 cycles of step 2 remain.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    idle(37, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    check("pause_at_step", 32'(obs_step), 32'd2);
    idle(40, 1'b0, 2'd0);
    check("paused_step", 32'(obs_step), 32'd2);
    check("paused_gate", 32'(obs_gate), 32'd0);
    check("paused_playing", 32'(obs_playing), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    n = 0; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      idle(1, 1'b0, 2'd0);
      if (obs_step == 2) n++;
      else found = 1;
    end
    check("resume_remaining", 32'(n), 32'd10);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

    // Tempo change at cnt=3 of step 1: step 1 keeps 16 cycles, step 2 gets 4.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 19; i++) begin
      idle(1, 1'b0, 2'd0);
      if (obs_step == 1) cnt_a++;
    end
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      idle(1, 1'b0, 2'd2);
      if (obs_step == 1) cnt_a++;
      else if (obs_step == 2) cnt_b++;
      else if (obs_step == 3) found = 1;
    end
    check("tempo_step1_len", 32'(cnt_a), 32'd16);
    check("tempo_step2_len", 32'(cnt_b), 32'd4);
    idle(1, 1'b0, 2'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    idle(1, 1'b0, 2'd0);
    check("stop_step", 32'(obs_step), 32'd0);
    check("stop_playing", 32'(obs_playing), 32'd0);

    // start+stop together while paused: stop wins.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    idle(20, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(3, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    idle(1, 1'b0, 2'd0);
    check("startstop_playing", 32'(obs_playing), 32'd0);
    check("startstop_step", 32'(obs_step), 32'd0);

    // Reset in the middle of playback.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    idle(25, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    idle(1, 1'b0, 2'd0);
    check("rstmid_step", 32'(obs_step), 32'd0);
    check("rstmid_gate", 32'(obs_gate), 32'd0);
    check("rstmid_playing", 32'(obs_playing), 32'd0);

    // Randomized control traffic against the model.
    rl = 1'b0; rts = 2'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) rl = ~rl;
      if ($urandom_range(0, 29) == 0) rts = 2'($urandom_range(0, 3));
      cyc(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 79) == 0), rl, rts);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
